// File: rtl/abs_diff_sweep_pkg.sv
// Shared types and helpers for the abs-diff sweep checker.
// Holds the FSM state encoding, the error-width rule and the
// zero-extended absolute-difference helper used by the compare stage.
package abs_diff_sweep_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } sweep_state_e;

  // Width that can hold any |exact - approx|: the wider of the two operands plus one.
  function automatic int calc_we(input int in_w, input int out_w);
    return ((out_w > in_w / 2) ? out_w : in_w / 2) + 1;
  endfunction

  // Helper operates on a fixed wide container; callers zero-extend in and truncate out.
  localparam int ABS_W = 32;

  function automatic logic [ABS_W-1:0] abs_sub(input logic [ABS_W-1:0] a,
                                                input logic [ABS_W-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

endpackage

// File: rtl/abs_diff_sweep_dly.sv
// LAT-deep valid+vector delay line that aligns issued vectors with the
// approximate circuit's output latency. With LAT=0 it collapses to wires.
// o_pending is high while any stage still holds a valid token.
module abs_diff_sweep_dly #(
  parameter int LAT   = 0,
  parameter int VEC_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [VEC_W-1:0] i_vec,
  output logic             o_valid,
  output logic [VEC_W-1:0] o_vec,
  output logic             o_pending
);

  generate
    if (LAT == 0) begin : g_wire
      logic w_unused;
      assign w_unused  = i_clk ^ i_rst;
      assign o_valid   = i_valid;
      assign o_vec     = i_vec;
      assign o_pending = 1'b0;
    end else begin : g_shift
      logic [LAT-1:0]   r_valid;
      logic [VEC_W-1:0] r_vec [LAT];

      // Valid bits shift every cycle and are cleared by reset.
      always_ff @(posedge i_clk) begin
        if (i_rst) begin
          r_valid <= '0;
        end else begin
          r_valid[0] <= i_valid;
          for (int i = 1; i < LAT; i++) begin
            r_valid[i] <= r_valid[i-1];
          end
        end
      end

      // Vector payload follows its valid bit; meaningless when the bit is low.
      always_ff @(posedge i_clk) begin
        r_vec[0] <= i_vec;
        for (int i = 1; i < LAT; i++) begin
          r_vec[i] <= r_vec[i-1];
        end
      end

      assign o_valid   = r_valid[LAT-1];
      assign o_vec     = r_vec[LAT-1];
      assign o_pending = |r_valid;
    end
  endgenerate

endmodule

// File: rtl/abs_diff_sweep_checker.sv
// Exhaustive sweep checker for an approximate |a-b| circuit.
// Drives every input vector once, compares each (latency-aligned) result
// against the exact absolute difference and gathers error statistics.
// Optional mean-error accumulator: define ABS_DIFF_SWEEP_MAE_EN to build
// sum_err; otherwise o_sum_err is tied to zero.
//
// Handshake: i_start is a single-cycle request, accepted only in IDLE or
// DONE (ignored otherwise, and i_rst in the same cycle wins). There is no
// back-pressure: once accepted, one vector is issued per cycle and results
// are valid while o_done is high, until the next accepted start or reset.
module abs_diff_sweep_checker
  import abs_diff_sweep_pkg::*;
#(
  parameter  int IN_W  = 4,
  parameter  int OUT_W = 2,
  parameter  int ET    = 1,
  parameter  int LAT   = 0,
  localparam int W_E   = calc_we(IN_W, OUT_W)
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  output logic [IN_W-1:0]       o_stim,
  input  logic [OUT_W-1:0]      i_approx_out,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_pass,
  output logic [IN_W:0]         o_err_count,
  output logic [W_E-1:0]        o_max_err,
  output logic [IN_W-1:0]       o_first_fail,
  output logic [IN_W+W_E-1:0]   o_sum_err,
  output logic [1:0]            o_dbg_state
);

  localparam int              HALF     = IN_W / 2;
  localparam logic [1:0]      S_IDLE   = 2'(IDLE);
  localparam logic [1:0]      S_RUN    = 2'(RUN);
  localparam logic [1:0]      S_DRAIN  = 2'(DRAIN);
  localparam logic [1:0]      S_DONE   = 2'(DONE);
  localparam logic [IN_W-1:0] VEC_LAST = '1;
  localparam logic [W_E-1:0]  ET_V     = W_E'(ET);

  logic [1:0]      r_state;
  logic [IN_W-1:0] r_vec;
  logic            w_start_ok;
  logic            w_dly_valid;
  logic [IN_W-1:0] w_dly_vec;
  logic            w_dly_pending;
  logic [W_E-1:0]  w_exact;
  logic [W_E-1:0]  w_err;
  logic            w_cmp_fail;
  logic            w_finish;

  logic            r_cmp_valid;
  logic [W_E-1:0]  r_cmp_err;
  logic [IN_W-1:0] r_cmp_vec;

  logic            r_fail;
  logic            r_pass;
  logic [IN_W:0]   r_err_count;
  logic [W_E-1:0]  r_max_err;
  logic [IN_W-1:0] r_first_fail;

  assign w_start_ok = i_start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Last compare retires on the same edge that enters DONE.
  assign w_finish   = (r_state == S_DRAIN) && !w_dly_pending;

  // Sweep FSM: issue vectors in RUN, wait out the delay line in DRAIN.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_vec   <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (w_start_ok) begin
            r_state <= S_RUN;
            r_vec   <= '0;
          end
        end
        S_RUN: begin
          if (r_vec == VEC_LAST) begin
            r_state <= S_DRAIN;
          end else begin
            r_vec <= r_vec + IN_W'(1);
          end
        end
        S_DRAIN: begin
          if (!w_dly_pending) begin
            r_state <= S_DONE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  abs_diff_sweep_dly #(
    .LAT   (LAT),
    .VEC_W (IN_W)
  ) u_dly (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_valid   (r_state == S_RUN),
    .i_vec     (r_vec),
    .o_valid   (w_dly_valid),
    .o_vec     (w_dly_vec),
    .o_pending (w_dly_pending)
  );

  // Exact result comes from the delayed vector so it lines up with i_approx_out.
  assign w_exact = W_E'(abs_sub(ABS_W'(w_dly_vec[HALF-1:0]),
                                ABS_W'(w_dly_vec[IN_W-1:HALF])));
  assign w_err   = W_E'(abs_sub(ABS_W'(w_exact), ABS_W'(i_approx_out)));

  // Compare stage: register the error of each aligned token.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cmp_valid <= 1'b0;
      r_cmp_err   <= '0;
      r_cmp_vec   <= '0;
    end else begin
      r_cmp_valid <= w_dly_valid;
      r_cmp_err   <= w_err;
      r_cmp_vec   <= w_dly_vec;
    end
  end

  assign w_cmp_fail = r_cmp_valid && (r_cmp_err > ET_V);

  // Statistics update per retired token; pass is frozen on DONE entry.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_fail       <= 1'b0;
      r_pass       <= 1'b0;
      r_err_count  <= '0;
      r_max_err    <= '0;
      r_first_fail <= '0;
    end else begin
      if (r_cmp_valid) begin
        if (r_cmp_err > r_max_err) begin
          r_max_err <= r_cmp_err;
        end
        if (w_cmp_fail) begin
          r_err_count <= r_err_count + (IN_W+1)'(1);
          if (!r_fail) begin
            r_first_fail <= r_cmp_vec;
            r_fail       <= 1'b1;
          end
        end
      end
      if (w_finish) begin
        r_pass <= ~(r_fail | w_cmp_fail);
      end
    end
  end

`ifdef ABS_DIFF_SWEEP_MAE_EN
  logic [IN_W+W_E-1:0] r_sum_err;

  // Running total of every retired error, for mean-error reporting.
  always_ff @(posedge i_clk) begin
    if (i_rst || w_start_ok) begin
      r_sum_err <= '0;
    end else if (r_cmp_valid) begin
      r_sum_err <= r_sum_err + (IN_W+W_E)'(r_cmp_err);
    end
  end

  assign o_sum_err = r_sum_err;
`else
  assign o_sum_err = '0;
`endif

  assign o_stim       = r_vec;
  assign o_busy       = (r_state == S_RUN) || (r_state == S_DRAIN);
  assign o_done       = (r_state == S_DONE);
  assign o_pass       = r_pass;
  assign o_err_count  = r_err_count;
  assign o_max_err    = r_max_err;
  assign o_first_fail = r_first_fail;
  assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_abs_diff_sweep_checker.sv
// Bench for abs_diff_sweep_checker: one LAT=0 instance and one LAT=2
// instance, each fed by a table-driven approximate circuit. Expected
// statistics come from a direct per-vector error calculation.
module tb_abs_diff_sweep_checker;

  localparam int IN_W = 4;
  localparam int OUT_W = 2;
  localparam int ET = 1;
  localparam int W_E = 3;
  localparam int NVEC = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;
  logic start0 = 1'b0;
  logic start2 = 1'b0;

  // ---------------- DUT wiring ----------------
  logic [IN_W-1:0]     stim0, stim2;
  logic [OUT_W-1:0]    approx0, approx2;
  logic                busy0, busy2, done0, done2, pass0, pass2;
  logic [IN_W:0]       cnt0, cnt2;
  logic [W_E-1:0]      max0, max2;
  logic [IN_W-1:0]     ff0, ff2;
  logic [IN_W+W_E-1:0] sum0, sum2;
  logic [1:0]          st0, st2;

  abs_diff_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .LAT(0)) dut0 (
    .i_clk(clk), .i_rst(rst), .i_start(start0), .o_stim(stim0),
    .i_approx_out(approx0), .o_busy(busy0), .o_done(done0), .o_pass(pass0),
    .o_err_count(cnt0), .o_max_err(max0), .o_first_fail(ff0),
    .o_sum_err(sum0), .o_dbg_state(st0)
  );

  abs_diff_sweep_checker #(.IN_W(IN_W), .OUT_W(OUT_W), .ET(ET), .LAT(2)) dut2 (
    .i_clk(clk), .i_rst(rst), .i_start(start2), .o_stim(stim2),
    .i_approx_out(approx2), .o_busy(busy2), .o_done(done2), .o_pass(pass2),
    .o_err_count(cnt2), .o_max_err(max2), .o_first_fail(ff2),
    .o_sum_err(sum2), .o_dbg_state(st2)
  );

  // ---------------- approximate circuit models ----------------
  logic [OUT_W-1:0] lut [NVEC];
  logic [OUT_W-1:0] p1, p2;
  int dly_sel = 2;

  always_comb approx0 = lut[stim0];

  always @(posedge clk) begin
    p1 <= lut[stim2];
    p2 <= p1;
  end
  assign approx2 = (dly_sel == 2) ? p2 : p1;

  // Selected-instance view for the shared sweep task.
  bit cur = 1'b0;
  logic [IN_W-1:0]     m_stim;
  logic                m_busy, m_done, m_pass;
  logic [IN_W:0]       m_cnt;
  logic [W_E-1:0]      m_max;
  logic [IN_W-1:0]     m_ff;
  logic [IN_W+W_E-1:0] m_sum;
  logic [1:0]          m_st;
  assign m_stim = cur ? stim2 : stim0;
  assign m_busy = cur ? busy2 : busy0;
  assign m_done = cur ? done2 : done0;
  assign m_pass = cur ? pass2 : pass0;
  assign m_cnt  = cur ? cnt2  : cnt0;
  assign m_max  = cur ? max2  : max0;
  assign m_ff   = cur ? ff2   : ff0;
  assign m_sum  = cur ? sum2  : sum0;
  assign m_st   = cur ? st2   : st0;

  // ---------------- scoreboard ----------------
  logic [15:0] exp_q [$];
  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_cmp++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
    end
  endtask

  // Reference: error of each vector straight from |a-b| and the table.
  // shift models a result that arrives one cycle early (stim holds at the end).
  task automatic model(input int shift);
    int cnt, mx, ff, sum, idx, a, b, ex, ap, er;
    cnt = 0; mx = 0; ff = 0; sum = 0;
    for (int v = 0; v < NVEC; v++) begin
      idx = (v + shift > NVEC - 1) ? NVEC - 1 : v + shift;
      a = v % 4;
      b = v / 4;
      ex = (a > b) ? a - b : b - a;
      ap = int'(lut[idx]);
      er = (ex > ap) ? ex - ap : ap - ex;
      if (er > mx) mx = er;
      if (er > ET) begin
        if (cnt == 0) ff = v;
        cnt++;
      end
      sum += er;
    end
    exp_q.push_back(16'(cnt == 0));
    exp_q.push_back(16'(cnt));
    exp_q.push_back(16'(mx));
    exp_q.push_back(16'(ff));
`ifdef ABS_DIFF_SWEEP_MAE_EN
    exp_q.push_back(16'(sum));
`else
    exp_q.push_back(16'd0);
`endif
  endtask

  task automatic fill_exact();
    for (int v = 0; v < NVEC; v++) begin
      int a, b;
      a = v % 4;
      b = v / 4;
      lut[v] = OUT_W'((a > b) ? a - b : b - a);
    end
  endtask

  task automatic set_start(input bit sel, input logic val);
    if (sel) start2 = val; else start0 = val;
  endtask

  // One full sweep on the selected instance, timing measured from start.
  task automatic run_sweep(input string tag, input bit sel, input int restart_at);
    int k, lat_exp;
    bit seen, stim_ok, busy_ok;
    logic [15:0] e;
    cur = sel;
    lat_exp = sel ? NVEC + 2 + 2 : NVEC + 2;
    @(negedge clk);
    set_start(sel, 1'b1);
    @(posedge clk);
    k = 0; seen = 1'b0; stim_ok = 1'b1; busy_ok = 1'b1;
    while (!seen && k < 200) begin
      @(negedge clk);
      k++;
      if (k == 1) set_start(sel, 1'b0);
      if (k == restart_at) set_start(sel, 1'b1);
      if (k == restart_at + 1) set_start(sel, 1'b0);
      if (k >= 1 && k <= NVEC && m_stim !== IN_W'(k - 1)) stim_ok = 1'b0;
      if (k < lat_exp && m_busy !== 1'b1) busy_ok = 1'b0;
      if (m_done === 1'b1) seen = 1'b1;
    end
    chk({tag, "_done_cycle"}, k, lat_exp);
    chk({tag, "_stim_seq"}, stim_ok, 1);
    chk({tag, "_busy_run"}, busy_ok, 1);
    chk({tag, "_busy_done"}, m_busy, 0);
    e = exp_q.pop_front(); chk({tag, "_pass"}, m_pass, e);
    e = exp_q.pop_front(); chk({tag, "_err_count"}, m_cnt, e);
    e = exp_q.pop_front(); chk({tag, "_max_err"}, m_max, e);
    e = exp_q.pop_front(); chk({tag, "_first_fail"}, m_ff, e);
    e = exp_q.pop_front(); chk({tag, "_sum_err"}, m_sum, e);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_stim"}, m_stim, 0);
    chk({tag, "_busy"}, m_busy, 0);
    chk({tag, "_done"}, m_done, 0);
    chk({tag, "_pass"}, m_pass, 0);
    chk({tag, "_cnt"}, m_cnt, 0);
    chk({tag, "_max"}, m_max, 0);
    chk({tag, "_ff"}, m_ff, 0);
    chk({tag, "_sum"}, m_sum, 0);
    chk({tag, "_state"}, m_st, 0);
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    fill_exact();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    cur = 1'b0; chk_zero("rst0");
    cur = 1'b1; chk_zero("rst2");

    // Exact circuit: clean pass.
    fill_exact(); model(0); run_sweep("exact", 1'b0, 0);

    // Vector 5 off by two.
    fill_exact(); lut[5] = lut[5] + 2'd2; model(0); run_sweep("v5", 1'b0, 0);

    // Every result off by one: at threshold everywhere.
    fill_exact();
    for (int v = 0; v < NVEC; v++) lut[v] = lut[v] ^ 2'd1;
    model(0); run_sweep("xor1", 1'b0, 0);

    // Random tables.
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < NVEC; v++) lut[v] = OUT_W'($urandom_range(0, 3));
      model(0); run_sweep($sformatf("rnd%0d", r), 1'b0, 0);
    end

    // start during RUN ignored, then restart from DONE clears stats.
    fill_exact(); model(0); run_sweep("restart_run", 1'b0, 8);
    for (int v = 0; v < NVEC; v++) lut[v] = OUT_W'($urandom_range(0, 3));
    lut[0] = 2'd3;
    model(0); run_sweep("rerun", 1'b0, 0);

    // Reset mid-sweep aborts everything.
    for (int v = 0; v < NVEC; v++) lut[v] = 2'd3;
    cur = 1'b0;
    @(negedge clk); start0 = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      if (k == 1) start0 = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    chk_zero("midrst");
    rst = 1'b0;
    fill_exact(); model(0); run_sweep("after_rst", 1'b0, 0);

    // LAT=2 instance, aligned and random.
    dly_sel = 2;
    fill_exact(); model(0); run_sweep("lat2_exact", 1'b1, 0);
    for (int v = 0; v < NVEC; v++) lut[v] = OUT_W'($urandom_range(0, 3));
    model(0); run_sweep("lat2_rnd", 1'b1, 0);

    // Result path one register short: early results must be flagged.
    dly_sel = 1;
    fill_exact(); model(1); run_sweep("lat2_misalign", 1'b1, 0);
    chk("lat2_misalign_fails", pass2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
